// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the gshare branch predictor.
// Holds the 2-bit counter encoding and its saturating next-state function.
package riscv_bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_t;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Saturates at both ends; never wraps.
  function automatic bp_ctr_t bp_ctr_next(bp_ctr_t c, logic taken);
    bp_ctr_t n;
    n = c;
    if (taken && (c != ST)) begin
      n = bp_ctr_t'(c + 2'b01);
    end else if (!taken && (c != SNT)) begin
      n = bp_ctr_t'(c - 2'b01);
    end
    return n;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/execute-side interface of the branch predictor.
// The master modport belongs to the pipeline, the slave modport to the predictor.
interface branch_predictor_if #(
  parameter int XLEN     = 64,
  parameter int IDX_BITS = 6
);
  logic                pred_valid_i;
  logic [XLEN-1:0]     pred_pc_i;
  logic                pred_taken_o;
  logic [IDX_BITS-1:0] pred_idx_o;
  logic                upd_valid_i;
  logic [IDX_BITS-1:0] upd_idx_i;
  logic                upd_taken_i;
  logic                upd_pred_taken_i;
  logic                mispredict_o;
  logic                mispredict_taken_o;

  modport master (
    output pred_valid_i, pred_pc_i, upd_valid_i, upd_idx_i, upd_taken_i, upd_pred_taken_i,
    input  pred_taken_o, pred_idx_o, mispredict_o, mispredict_taken_o
  );

  modport slave (
    input  pred_valid_i, pred_pc_i, upd_valid_i, upd_idx_i, upd_taken_i, upd_pred_taken_i,
    output pred_taken_o, pred_idx_o, mispredict_o, mispredict_taken_o
  );
endinterface

// File: rtl/bp_sat_counter2.sv
// One 2-bit saturating direction counter with enable and async reset to INIT_CTR.
module bp_sat_counter2
  import riscv_bp_pkg::*;
#(
  parameter bp_ctr_t INIT_CTR = WNT
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    en_i,
  input  logic    taken_i,
  output bp_ctr_t ctr_o
);

  bp_ctr_t ctr_q, ctr_d;

  always_comb begin
    ctr_d = ctr_q;
    if (en_i) begin
      ctr_d = bp_ctr_next(ctr_q, taken_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr_q <= INIT_CTR;
    end else begin
      ctr_q <= ctr_d;
    end
  end

  assign ctr_o = ctr_q;

endmodule

// File: rtl/branch_predictor.sv
// Gshare conditional-branch predictor: PC ^ GHR indexes 2-bit counters, GHR updated at resolve.
// Optional BRANCH_PRED_STATS_EN adds saturating branch / mispredict statistics counters.
module branch_predictor
  import riscv_bp_pkg::*;
#(
  parameter int         XLEN     = 64,
  parameter int         IDX_BITS = 6,
  parameter int         GHR_BITS = 6,
  parameter logic [1:0] INIT_CTR = 2'b01
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef BRANCH_PRED_STATS_EN
  output logic [31:0] stat_branches_o,
  output logic [31:0] stat_mispred_o,
`endif
  branch_predictor_if.slave bus
);

  localparam int NUM_CTR = 2**IDX_BITS;

  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic                mispredict_q, mispredict_d;
  logic                mispredict_taken_q, mispredict_taken_d;
  logic [IDX_BITS-1:0] pred_idx;
  bp_ctr_t             ctr [NUM_CTR];

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign pred_idx          = bus.pred_pc_i[IDX_BITS+1:2] ^ IDX_BITS'(ghr_q);
  assign bus.pred_idx_o    = pred_idx;
  assign bus.pred_taken_o  = ctr[pred_idx][1];

  for (genvar i = 0; i < NUM_CTR; i++) begin : g_ctr
    bp_sat_counter2 #(
      .INIT_CTR (bp_ctr_t'(INIT_CTR))
    ) u_ctr (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (bus.upd_valid_i && (bus.upd_idx_i == IDX_BITS'(i))),
      .taken_i (bus.upd_taken_i),
      .ctr_o   (ctr[i])
    );
  end

  always_comb begin
    ghr_d              = ghr_q;
    mispredict_d       = 1'b0;
    mispredict_taken_d = mispredict_taken_q;
    if (bus.upd_valid_i) begin
      ghr_d              = {ghr_q[GHR_BITS-2:0], bus.upd_taken_i};
      mispredict_d       = bus.upd_taken_i != bus.upd_pred_taken_i;
      mispredict_taken_d = bus.upd_taken_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q              <= '0;
      mispredict_q       <= 1'b0;
      mispredict_taken_q <= 1'b0;
    end else begin
      ghr_q              <= ghr_d;
      mispredict_q       <= mispredict_d;
      mispredict_taken_q <= mispredict_taken_d;
    end
  end

  assign bus.mispredict_o       = mispredict_q;
  assign bus.mispredict_taken_o = mispredict_taken_q;

  // pred_valid_i only qualifies the outputs for fetch; the lookup itself is unconditional.
  logic unused_inputs;
  assign unused_inputs = bus.pred_valid_i ^ (^bus.pred_pc_i[XLEN-1:IDX_BITS+2])
                         ^ (^bus.pred_pc_i[1:0]);

`ifdef BRANCH_PRED_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispred_q, stat_mispred_d;

  always_comb begin
    stat_branches_d = stat_branches_q;
    stat_mispred_d  = stat_mispred_q;
    if (bus.upd_valid_i && (stat_branches_q != 32'hFFFF_FFFF)) begin
      stat_branches_d = stat_branches_q + 32'd1;
    end
    if (bus.upd_valid_i && (bus.upd_taken_i != bus.upd_pred_taken_i)
        && (stat_mispred_q != 32'hFFFF_FFFF)) begin
      stat_mispred_d = stat_mispred_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign stat_branches_o = stat_branches_q;
  assign stat_mispred_o  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed scenarios followed by random traffic
// against an array-based gshare reference model.
module tb_branch_predictor;
  import riscv_bp_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_predictor_if #(.XLEN(64), .IDX_BITS(6)) bus ();

`ifdef BRANCH_PRED_STATS_EN
  logic [31:0] stat_branches, stat_mispred;
`endif

  branch_predictor dut (
    .clk             (clk),
    .rst_n           (rst_n),
`ifdef BRANCH_PRED_STATS_EN
    .stat_branches_o (stat_branches),
    .stat_mispred_o  (stat_mispred),
`endif
    .bus             (bus)
  );

  int total = 0;
  int bad   = 0;

  int m_ctr [64];
  int m_ghr;
  int m_branches;
  int m_mispred;

  typedef struct {
    bit valid;
    bit mp;
    bit mt;
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 64; i++) m_ctr[i] = 1;
    m_ghr      = 0;
    m_branches = 0;
    m_mispred  = 0;
  endfunction

  function automatic int m_idx(logic [63:0] pc);
    return int'((pc >> 2) & 64'h3f) ^ m_ghr;
  endfunction

  function automatic logic [63:0] pc_for(int idx);
    return 64'h1000 | (64'((idx ^ m_ghr) & 63) << 2);
  endfunction

  // One cycle of stimulus: lookup checked against the model, update queued for the monitor.
  task automatic step(bit pv, logic [63:0] pc, bit uv, int uidx, bit ut, bit upt, string tag);
    exp_t e;
    int   ei;
    @(negedge clk);
    bus.pred_valid_i     = pv;
    bus.pred_pc_i        = pc;
    bus.upd_valid_i      = uv;
    bus.upd_idx_i        = 6'(uidx);
    bus.upd_taken_i      = ut;
    bus.upd_pred_taken_i = upt;
    #1;
    if (pv) begin
      ei = m_idx(pc);
      chk({tag, "_idx"}, bus.pred_idx_o, ei);
      chk({tag, "_taken"}, bus.pred_taken_o, (m_ctr[ei] >= 2) ? 1 : 0);
    end
    e.valid = uv;
    e.mp    = uv && (ut != upt);
    e.mt    = ut;
    if (uv) begin
      if (ut) m_ctr[uidx] = (m_ctr[uidx] == 3) ? 3 : m_ctr[uidx] + 1;
      else    m_ctr[uidx] = (m_ctr[uidx] == 0) ? 0 : m_ctr[uidx] - 1;
      m_ghr = ((m_ghr << 1) | int'(ut)) & 63;
      m_branches++;
      if (ut != upt) m_mispred++;
    end
    sb_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("mispredict", bus.mispredict_o, e.mp);
        if (e.valid) chk("mispredict_taken", bus.mispredict_taken_o, e.mt);
      end
    end
  end

  initial begin : stimulus
    logic [63:0] pc;
    logic [6:0]  opc;
    bit          pv, uv, ut, upt;
    int          uidx;

    bus.pred_valid_i     = 1'b0;
    bus.pred_pc_i        = '0;
    bus.upd_valid_i      = 1'b0;
    bus.upd_idx_i        = '0;
    bus.upd_taken_i      = 1'b0;
    bus.upd_pred_taken_i = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state and first lookup
    step(1, 64'h1000, 0, 0, 0, 0, "t1");
    chk("t1_idx_const", bus.pred_idx_o, 0);
    chk("t1_taken_const", bus.pred_taken_o, 0);
    chk("t1_mp_reset", bus.mispredict_o, 0);

    // Saturating increments of idx 5
    repeat (3) step(0, 64'h0, 1, 5, 1, 0, "t2");

    // GHR = 000111
    step(1, 64'h1014, 0, 0, 0, 0, "t3");
    chk("t3_idx_const", bus.pred_idx_o, 2);

    step(1, pc_for(5), 0, 0, 0, 0, "t2_sat");
    chk("t2_sat_taken", bus.pred_taken_o, 1);
    step(0, 64'h0, 1, 5, 0, 0, "t2_dec");
    step(1, pc_for(5), 0, 0, 0, 0, "t2_after_dec");
    chk("t2_no_wrap", bus.pred_taken_o, 1);

    // Same-cycle update and lookup of one index
    step(0, 64'h0, 1, 2, 1, 1, "t4_train");
    step(1, pc_for(2), 1, 2, 0, 1, "t4");
    chk("t4_old_value", bus.pred_taken_o, 1);
    step(1, pc_for(2), 0, 0, 0, 0, "t4_next");
    chk("t4_new_value", bus.pred_taken_o, 0);

    // Correct prediction, then a mispredict interrupted by reset
    step(0, 64'h0, 1, 9, 1, 1, "t5");
    step(0, 64'h0, 1, 9, 0, 1, "t5b");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    m_reset();
    bus.upd_valid_i = 1'b0;
    bus.pred_pc_i   = 64'h14;
    #1;
    chk("t5_rst_mp", bus.mispredict_o, 0);
    chk("t5_rst_mt", bus.mispredict_taken_o, 0);
    chk("t5_rst_idx", bus.pred_idx_o, 5);
    chk("t5_rst_taken", bus.pred_taken_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i += 9) step(1, pc_for(i), 0, 0, 0, 0, "t5_init");

    // Random traffic; only conditional branches reach the predictor
    for (int n = 0; n < 1500; n++) begin
      opc = ($urandom_range(0, 3) != 0) ? OPC_BRANCH : 7'b0110011;
      pv  = (opc == OPC_BRANCH) && ($urandom_range(0, 1) == 1);
      pc  = {$urandom, $urandom};
      uv  = ($urandom_range(0, 9) < 7);
      uidx = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 63);
      ut  = $urandom_range(0, 1) == 1;
      upt = ($urandom_range(0, 3) == 0) ? ~ut : ut;
      step(pv, pc, uv, uidx, ut, upt, "rnd");
    end

    @(negedge clk);
    bus.upd_valid_i  = 1'b0;
    bus.pred_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #2;
`ifdef BRANCH_PRED_STATS_EN
    chk("stat_branches", stat_branches, m_branches);
    chk("stat_mispred", stat_mispred, m_mispred);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
